uart_key_rx: RTL and testbench

- Upstream key source for the menu and game control stages.
- Receives 8N1 ASCII bytes from the PC terminal on the Basys3 USB-UART line (ESC 0x1B, ENTER 0x0D, '1'..'4', arrows/letters for the snake).
- Presents each accepted byte on `key` for a bounded number of cycles, then returns `key` to 0x00, so consumers see one event per keystroke.
- Runs in the pixel clock domain.

---
 rtl/uart_key_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_key_rx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_key_rx.sv
// 8N1 UART key receiver: presents each accepted byte on key for KEY_HOLD cycles, then 0x00.
// Define KEY_FILTER_EN to accept only the menu/game keys (ESC, ENTER, '1'..'4', w/a/s/d).
module uart_key_rx #(
  parameter int CLKS_PER_BIT = 564,
  parameter int KEY_HOLD     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] key,
  output logic       key_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, HOLD, BREAK} state_t;

  localparam logic [15:0] HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  HOLD_MAX = 3'(KEY_HOLD);

  state_t      state_q, state_d;
  logic        rxMeta_q, rxs_q;
  logic [15:0] bitCnt_q, bitCnt_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [2:0]  holdCnt_q, holdCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  key_q, key_d;
  logic        keyValid_q, keyValid_d;
  logic        frameErr_q, frameErr_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic        bitEnd;

`ifdef KEY_FILTER_EN
  always_comb begin
    case (shift_q)
      8'h1B, 8'h0D, 8'h31, 8'h32, 8'h33, 8'h34,
      8'h77, 8'h61, 8'h73, 8'h64: accept = 1'b1;
      default:                    accept = 1'b0;
    endcase
  end
`else
  assign accept = 1'b1;
`endif

  assign bitEnd = (bitCnt_q == FULL_M1);

  // Synchronizer flops reset to the idle line level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q   <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      bitIdx_q   <= '0;
      holdCnt_q  <= '0;
      shift_q    <= '0;
      key_q      <= '0;
      keyValid_q <= 1'b0;
      frameErr_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rxMeta_q   <= rx;
      rxs_q      <= rxMeta_q;
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      bitIdx_q   <= bitIdx_d;
      holdCnt_q  <= holdCnt_d;
      shift_q    <= shift_d;
      key_q      <= key_d;
      keyValid_q <= keyValid_d;
      frameErr_q <= frameErr_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    bitIdx_d  = bitIdx_q;
    holdCnt_d = holdCnt_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d  = START;
          bitCnt_d = '0;
        end
      end
      START: begin
        if (bitCnt_q == HALF_M1) begin
          bitCnt_d = '0;
          bitIdx_d = '0;
          state_d  = rxs_q ? IDLE : DATA;
        end else begin
          bitCnt_d = bitCnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bitEnd) begin
          shift_d[bitIdx_q] = rxs_q;
          bitCnt_d          = '0;
          if (bitIdx_q == 3'd7) state_d = STOP;
          else bitIdx_d = bitIdx_q + 3'd1;
        end else begin
          bitCnt_d = bitCnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bitEnd) begin
          bitCnt_d = '0;
          if (!rxs_q) begin
            state_d = BREAK;
          end else if (accept) begin
            state_d   = HOLD;
            holdCnt_d = 3'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bitCnt_d = bitCnt_q + 16'd1;
        end
      end
      HOLD: begin
        if (holdCnt_q == HOLD_MAX) begin
          state_d   = IDLE;
          holdCnt_d = '0;
        end else begin
          holdCnt_d = holdCnt_q + 3'd1;
        end
      end
      BREAK: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed one edge early so the registered copies line up with state.
  always_comb begin
    key_d      = key_q;
    keyValid_d = 1'b0;
    frameErr_d = 1'b0;
    busy_d     = (state_d != IDLE);
    case (state_q)
      STOP: begin
        if (bitEnd) begin
          if (!rxs_q) begin
            frameErr_d = 1'b1;
          end else if (accept) begin
            key_d      = shift_q;
            keyValid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (holdCnt_q == HOLD_MAX) key_d = 8'h00;
      end
      default: ;
    endcase
  end

  assign key       = key_q;
  assign key_valid = keyValid_q;
  assign frame_err = frameErr_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_key_rx.sv
// Bench for uart_key_rx: two instances (hold of 1 and 3 cycles) share one UART line;
// per-frame expectations come from a frame-level model, observations from event monitors.
module tb_uart_key_rx;

  localparam int CPB    = 16;
  localparam int HOLD_A = 1;
  localparam int HOLD_B = 3;
`ifdef KEY_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] keyA, keyB;
  logic       vA, vB, fA, fB, bA, bB;

  int checks = 0;
  int errors = 0;

  uart_key_rx #(.CLKS_PER_BIT(CPB), .KEY_HOLD(HOLD_A)) dutA (
    .clk(clk), .rst(rst), .rx(rx),
    .key(keyA), .key_valid(vA), .frame_err(fA), .rx_busy(bA)
  );

  uart_key_rx #(.CLKS_PER_BIT(CPB), .KEY_HOLD(HOLD_B)) dutB (
    .clk(clk), .rst(rst), .rx(rx),
    .key(keyB), .key_valid(vB), .frame_err(fB), .rx_busy(bB)
  );

  always #5 clk = ~clk;

  // Observed events: key_valid bytes, frame_err pulses, and nonzero key run lengths.
  int           vCntA = 0, ferrA = 0, runCntA = 0, runSumA = 0, curRunA = 0;
  int           vCntB = 0, ferrB = 0, runCntB = 0, runSumB = 0, curRunB = 0;
  logic [127:0] vLogA = '0, vLogB = '0;
  logic [7:0]   prevA = '0, prevB = '0;

  always @(negedge clk) begin
    if (vA === 1'b1) begin vLogA = {vLogA[119:0], keyA}; vCntA++; end
    if (fA === 1'b1) ferrA++;
    if (keyA != 8'h00 && keyA == prevA) curRunA++;
    else begin
      if (curRunA > 0) begin runCntA++; runSumA += curRunA; end
      curRunA = (keyA != 8'h00) ? 1 : 0;
    end
    prevA = keyA;
  end

  always @(negedge clk) begin
    if (vB === 1'b1) begin vLogB = {vLogB[119:0], keyB}; vCntB++; end
    if (fB === 1'b1) ferrB++;
    if (keyB != 8'h00 && keyB == prevB) curRunB++;
    else begin
      if (curRunB > 0) begin runCntB++; runSumB += curRunB; end
      curRunB = (keyB != 8'h00) ? 1 : 0;
    end
    prevB = keyB;
  end

  // Frame-level reference model.
  int           expCnt = 0, expFerr = 0, expRuns = 0;
  logic [127:0] expLog = '0;

  function automatic bit modelAccepts(input logic [7:0] b);
    if (!FILTER) return 1'b1;
    return b inside {8'h1B, 8'h0D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h77, 8'h61, 8'h73, 8'h64};
  endfunction

  task automatic modelFrame(input logic [7:0] b, input logic stopBit);
    if (!stopBit) expFerr++;
    else if (modelAccepts(b)) begin
      expLog = {expLog[119:0], b};
      expCnt++;
      if (b != 8'h00) expRuns++;
    end
  endtask

  task automatic clearAll();
    vCntA = 0; ferrA = 0; runCntA = 0; runSumA = 0; vLogA = '0;
    vCntB = 0; ferrB = 0; runCntB = 0; runSumB = 0; vLogB = '0;
    expCnt = 0; expFerr = 0; expRuns = 0; expLog = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic driveBit(input logic v);
    rx = v;
    idle(CPB);
  endtask

  // Drives one 8N1 frame, LSB first; the stop level is selectable to force framing errors.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(stopBit);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    if ({keyA, vA, fA, bA} !== 11'd0) begin
      errors++; $display("[TB] FAIL resetA got key=%h v=%b f=%b busy=%b want all 0", keyA, vA, fA, bA);
    end
    checks++;
    if ({keyB, vB, fB, bB} !== 11'd0) begin
      errors++; $display("[TB] FAIL resetB got key=%h v=%b f=%b busy=%b want all 0", keyB, vB, fB, bB);
    end
    checks++;
    rst = 1'b0;
    idle(4);
    if ({keyA, vA, fA, bA, keyB, vB, fB, bB} !== 22'd0) begin
      errors++; $display("[TB] FAIL post_reset_idle got busyA=%b busyB=%b keyA=%h keyB=%h want 0", bA, bB, keyA, keyB);
    end
    checks++;
    clearAll();
  endtask

  task automatic test_single();
    clearAll();
    fork
      applyStimulus(8'h1B, 1'b1);
      begin
        idle(40);
        if ({bA, bB} !== 2'b11) begin
          errors++; $display("[TB] FAIL busy_mid_frame got %b%b want 11", bA, bB);
        end
        checks++;
      end
    join
    modelFrame(8'h1B, 1'b1);
    idle(40);
    if ({bA, bB} !== 2'b00) begin
      errors++; $display("[TB] FAIL busy_after_hold got %b%b want 00", bA, bB);
    end
    checks++;
    if (vCntA !== expCnt || vLogA !== expLog || vCntB !== expCnt || vLogB !== expLog) begin
      errors++; $display("[TB] FAIL single_valid got A=%0d/%h B=%0d/%h want %0d/%h", vCntA, vLogA, vCntB, vLogB, expCnt, expLog);
    end
    checks++;
    if (runCntA !== expRuns || runSumA !== expRuns * HOLD_A || runCntB !== expRuns || runSumB !== expRuns * HOLD_B) begin
      errors++; $display("[TB] FAIL single_hold got runsA=%0d sumA=%0d runsB=%0d sumB=%0d want runs=%0d", runCntA, runSumA, runCntB, runSumB, expRuns);
    end
    checks++;
    if (ferrA !== expFerr || ferrB !== expFerr) begin
      errors++; $display("[TB] FAIL single_ferr got %0d/%0d want %0d", ferrA, ferrB, expFerr);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    clearAll();
    applyStimulus(8'h0D, 1'b1);
    applyStimulus(8'h31, 1'b1);
    modelFrame(8'h0D, 1'b1);
    modelFrame(8'h31, 1'b1);
    idle(40);
    if (vCntA !== expCnt || vLogA !== expLog || vCntB !== expCnt || vLogB !== expLog) begin
      errors++; $display("[TB] FAIL b2b_valid got A=%0d/%h B=%0d/%h want %0d/%h", vCntA, vLogA, vCntB, vLogB, expCnt, expLog);
    end
    checks++;
    if (runCntB !== expRuns || runSumB !== expRuns * HOLD_B || runCntA !== expRuns || runSumA !== expRuns * HOLD_A) begin
      errors++; $display("[TB] FAIL b2b_hold got runsA=%0d sumA=%0d runsB=%0d sumB=%0d want runs=%0d", runCntA, runSumA, runCntB, runSumB, expRuns);
    end
    checks++;
  endtask

  task automatic test_glitch();
    clearAll();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(2);
    if ({bA, bB} !== 2'b11) begin
      errors++; $display("[TB] FAIL glitch_busy got %b%b want 11", bA, bB);
    end
    checks++;
    idle(30);
    if ({bA, bB} !== 2'b00 || vCntA !== 0 || vCntB !== 0 || ferrA !== 0 || ferrB !== 0) begin
      errors++; $display("[TB] FAIL glitch_quiet got busy=%b%b valid=%0d/%0d ferr=%0d/%0d want all 0", bA, bB, vCntA, vCntB, ferrA, ferrB);
    end
    checks++;
  endtask

  task automatic test_frame_error();
    clearAll();
    applyStimulus(8'h32, 1'b0);
    modelFrame(8'h32, 1'b0);
    idle(100);
    rx = 1'b1;
    idle(20);
    if (ferrA !== expFerr || ferrB !== expFerr || vCntA !== 0 || vCntB !== 0 || runCntA !== 0 || runCntB !== 0) begin
      errors++; $display("[TB] FAIL break_ferr got ferr=%0d/%0d valid=%0d/%0d runs=%0d/%0d want ferr=%0d", ferrA, ferrB, vCntA, vCntB, runCntA, runCntB, expFerr);
    end
    checks++;
    applyStimulus(8'h33, 1'b1);
    modelFrame(8'h33, 1'b1);
    idle(40);
    if (vCntA !== expCnt || vLogA !== expLog || vCntB !== expCnt || vLogB !== expLog || ferrA !== expFerr || ferrB !== expFerr) begin
      errors++; $display("[TB] FAIL after_break got A=%0d/%h B=%0d/%h ferr=%0d/%0d want %0d/%h ferr=%0d", vCntA, vLogA, vCntB, vLogB, ferrA, ferrB, expCnt, expLog, expFerr);
    end
    checks++;
  endtask

  task automatic test_zero_byte();
    clearAll();
    applyStimulus(8'h00, 1'b1);
    modelFrame(8'h00, 1'b1);
    idle(40);
    if (vCntA !== expCnt || vLogA !== expLog || vCntB !== expCnt || vLogB !== expLog || runCntA !== 0 || runCntB !== 0) begin
      errors++; $display("[TB] FAIL zero_byte got valid=%0d/%0d runs=%0d/%0d want valid=%0d runs=0", vCntA, vCntB, runCntA, runCntB, expCnt);
    end
    checks++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    clearAll();
    b = 8'h34;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(b[i]);
    rx = b[4];
    idle(8);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    if (keyA !== 8'h00 || keyB !== 8'h00 || bA !== 1'b0 || bB !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_abort got keyA=%h keyB=%h busy=%b%b want 00 00 00", keyA, keyB, bA, bB);
    end
    checks++;
    rx = 1'b1;
    idle(8 + 4 * CPB);
    if (vCntA !== 0 || vCntB !== 0 || ferrA !== 0 || ferrB !== 0 || runCntA !== 0 || runCntB !== 0) begin
      errors++; $display("[TB] FAIL reset_no_output got valid=%0d/%0d ferr=%0d/%0d runs=%0d/%0d want 0", vCntA, vCntB, ferrA, ferrB, runCntA, runCntB);
    end
    checks++;
    applyStimulus(8'h34, 1'b1);
    modelFrame(8'h34, 1'b1);
    idle(40);
    if (vCntA !== expCnt || vLogA !== expLog || vCntB !== expCnt || vLogB !== expLog) begin
      errors++; $display("[TB] FAIL reset_recover got A=%0d/%h B=%0d/%h want %0d/%h", vCntA, vLogA, vCntB, vLogB, expCnt, expLog);
    end
    checks++;
  endtask

  task automatic test_filter();
    clearAll();
    applyStimulus(8'h7A, 1'b1);
    applyStimulus(8'h31, 1'b1);
    modelFrame(8'h7A, 1'b1);
    modelFrame(8'h31, 1'b1);
    idle(40);
    if (vCntA !== expCnt || vLogA !== expLog || vCntB !== expCnt || vLogB !== expLog || ferrA !== 0 || ferrB !== 0) begin
      errors++; $display("[TB] FAIL filter got A=%0d/%h B=%0d/%h ferr=%0d/%0d want %0d/%h", vCntA, vLogA, vCntB, vLogB, ferrA, ferrB, expCnt, expLog);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [7:0] keys [10];
    logic [7:0] b;
    keys = '{8'h1B, 8'h0D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h77, 8'h61, 8'h73, 8'h64};
    clearAll();
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) b = keys[$urandom_range(0, 9)];
      applyStimulus(b, 1'b1);
      modelFrame(b, 1'b1);
      idle($urandom_range(0, 20));
    end
    idle(40);
    if (vCntA !== expCnt || vLogA !== expLog || vCntB !== expCnt || vLogB !== expLog) begin
      errors++; $display("[TB] FAIL random_valid got A=%0d/%h B=%0d/%h want %0d/%h", vCntA, vLogA, vCntB, vLogB, expCnt, expLog);
    end
    checks++;
    if (runCntA !== expRuns || runSumA !== expRuns * HOLD_A || runCntB !== expRuns || runSumB !== expRuns * HOLD_B || ferrA !== 0 || ferrB !== 0) begin
      errors++; $display("[TB] FAIL random_hold got runsA=%0d sumA=%0d runsB=%0d sumB=%0d ferr=%0d/%0d want runs=%0d", runCntA, runSumA, runCntB, runSumB, ferrA, ferrB, expRuns);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_zero_byte();
    test_reset_mid_frame();
    test_filter();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
